// File: rtl/if_fetch_stage_pkg.sv
// Shared definitions for the instruction-fetch stage: widths, reset PC,
// special instruction encodings, fetch FSM states and small helpers.
package if_fetch_stage_pkg;

  localparam int ADDR_W = 16;
  localparam int INST_W = 16;

  localparam logic [ADDR_W-1:0] RESET_PC  = 16'h0000;
  localparam logic [ADDR_W-1:0] PC_INC    = 16'h0002;
  localparam logic [ADDR_W-1:0] PC_ALIGN  = 16'hFFFE;
  localparam logic [INST_W-1:0] NOP_INST  = 16'h0000;
  localparam logic [INST_W-1:0] HALT_INST = 16'hFFFF;

  typedef enum logic [0:0] {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } fetch_state_e;

  // Instructions are 16-bit, so every fetch address is even.
  function automatic logic [ADDR_W-1:0] align_pc(input logic [ADDR_W-1:0] target);
    return target & PC_ALIGN;
  endfunction

  // Event counter that sticks at its maximum instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] cnt);
    return (cnt == 32'hFFFF_FFFF) ? cnt : (cnt + 32'd1);
  endfunction

endpackage

// File: rtl/if_fetch_stage_if.sv
// Instruction-memory bus between the fetch stage (master) and im (slave).
interface if_fetch_stage_if;
  import if_fetch_stage_pkg::*;

  logic [ADDR_W-1:0] im_address;
  logic [INST_W-1:0] im_inst;

  modport master (output im_address, input im_inst);
  modport slave  (input im_address, output im_inst);
endinterface

// File: rtl/if_fetch_stage_ifid_reg.sv
// IF/ID pipeline register: holds instruction, its PC and a valid flag.
// Priority: rst > flush (insert bubble) > load > hold.
module if_fetch_stage_ifid_reg
  import if_fetch_stage_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              flush,
  input  logic [INST_W-1:0] load_inst,
  input  logic [ADDR_W-1:0] load_pc,
  output logic [INST_W-1:0] inst,
  output logic [ADDR_W-1:0] pc,
  output logic              valid
);

  logic [INST_W-1:0] inst_d, inst_q;
  logic [ADDR_W-1:0] pc_d, pc_q;
  logic              valid_d, valid_q;

  // Next-state selection for the IF/ID contents.
  always_comb begin
    inst_d  = inst_q;
    pc_d    = pc_q;
    valid_d = valid_q;
    if (flush) begin
      inst_d  = NOP_INST;
      pc_d    = {ADDR_W{1'b0}};
      valid_d = 1'b0;
    end else if (load) begin
      inst_d  = load_inst;
      pc_d    = load_pc;
      valid_d = 1'b1;
    end else begin
      inst_d  = inst_q;
      pc_d    = pc_q;
      valid_d = valid_q;
    end
  end

  // IF/ID storage with synchronous reset to a bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      inst_q  <= NOP_INST;
      pc_q    <= {ADDR_W{1'b0}};
      valid_q <= 1'b0;
    end else begin
      inst_q  <= inst_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
    end
  end

  assign inst  = inst_q;
  assign pc    = pc_q;
  assign valid = valid_q;

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives im, fills IF/ID, and handles
// stall, redirect/flush and halt. Optional macro FETCH_PERF_EN adds
// saturating fetch/stall performance counters.
module if_fetch_stage
  import if_fetch_stage_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    stall,
  input  logic                    redirect,
  input  logic [ADDR_W-1:0]       redirect_target,
  if_fetch_stage_if.master        im_bus,
  output logic [INST_W-1:0]       ifid_inst,
  output logic [ADDR_W-1:0]       ifid_pc,
  output logic                    ifid_valid,
  output logic                    halted
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]             perf_fetch_cnt,
  output logic [31:0]             perf_stall_cnt
`endif
);

  logic [ADDR_W-1:0] pc_d, pc_q;
  fetch_state_e      state_d, state_q;
  logic              ifid_load_s;
  logic              ifid_flush_s;

  // PC, FSM and IF/ID control: redirect beats stall beats normal fetch.
  always_comb begin
    pc_d         = pc_q;
    state_d      = state_q;
    ifid_load_s  = 1'b0;
    ifid_flush_s = 1'b0;
    if (redirect) begin
      pc_d         = align_pc(redirect_target);
      state_d      = ST_RUN;
      ifid_flush_s = 1'b1;
    end else if (stall) begin
      pc_d    = pc_q;
      state_d = state_q;
    end else begin
      case (state_q)
        ST_RUN: begin
          ifid_load_s = 1'b1;
          if (im_bus.im_inst == HALT_INST) begin
            // Halt reaches decode as a real instruction; fetch parks here.
            pc_d    = pc_q;
            state_d = ST_HALTED;
          end else begin
            pc_d    = pc_q + PC_INC;
            state_d = ST_RUN;
          end
        end
        ST_HALTED: begin
          ifid_flush_s = 1'b1;
        end
        default: begin
          state_d      = ST_RUN;
          ifid_flush_s = 1'b1;
        end
      endcase
    end
  end

  // PC and fetch-state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= RESET_PC;
      state_q <= ST_RUN;
    end else begin
      pc_q    <= pc_d;
      state_q <= state_d;
    end
  end

  if_fetch_stage_ifid_reg u_ifid_reg (
    .clk       (clk),
    .rst       (rst),
    .load      (ifid_load_s),
    .flush     (ifid_flush_s),
    .load_inst (im_bus.im_inst),
    .load_pc   (pc_q),
    .inst      (ifid_inst),
    .pc        (ifid_pc),
    .valid     (ifid_valid)
  );

  assign im_bus.im_address = pc_q;
  assign halted            = (state_q == ST_HALTED);

`ifdef FETCH_PERF_EN
  logic [31:0] fetch_cnt_d, fetch_cnt_q;
  logic [31:0] stall_cnt_d, stall_cnt_q;

  // Count valid loads into IF/ID and stall cycles not overridden by redirect.
  always_comb begin
    fetch_cnt_d = fetch_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (ifid_load_s) begin
      fetch_cnt_d = sat_inc(fetch_cnt_q);
    end else begin
      fetch_cnt_d = fetch_cnt_q;
    end
    if (stall && !redirect) begin
      stall_cnt_d = sat_inc(stall_cnt_q);
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
  end

  // Performance counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_cnt_q <= 32'd0;
      stall_cnt_q <= 32'd0;
    end else begin
      fetch_cnt_q <= fetch_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign perf_fetch_cnt = fetch_cnt_q;
  assign perf_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
Instruction-fetch stage directly upstream of the instruction memory (im) and feeding the decode stage. Owns the program counter and drives im's address. Captures the returned 16-bit instruction into the IF/ID pipeline register. Handles stall, branch/jump redirect with flush, and a halt instruction.

Parameters:
ADDR_W, 16, PC / im address width
INST_W, 16, instruction width
RESET_PC, 16'h0000, PC value after reset
PC_INC, 2, byte increment per sequential fetch (16-bit instructions, byte-addressed im)
NOP_INST, 16'h0000, encoding inserted as a bubble
HALT_INST, 16'hFFFF, encoding that stops fetch

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  reset; synchronous, active-high
stall  in  1  hazard unit: hold PC and IF/ID this cycle
redirect  in  1  branch/jump resolved taken in a later stage
redirect_target  in  ADDR_W  new PC when redirect=1
im_address  out  ADDR_W  address to im; combinational copy of pc
im_inst  in  INST_W  instruction from im; combinational in im_address
ifid_inst  out  INST_W  registered instruction to decode
ifid_pc  out  ADDR_W  registered PC of ifid_inst
ifid_valid  out  1  ifid_inst is real (not bubble)
halted  out  1  fetch is in HALTED state

Behaviour:
- Reset (rst=1 at edge): pc=RESET_PC, ifid_inst=NOP_INST, ifid_pc=0, ifid_valid=0, halted=0, state=RUN. rst overrides all inputs; mid-operation reset discards in-flight IF/ID content.
- im_address = pc at all times, no added latency; im_inst is sampled the same cycle.
- FSM states: RUN, HALTED. halted = (state==HALTED).
- Edge priority: rst > redirect > stall > normal.
- redirect=1 (either state): pc <= {redirect_target[ADDR_W-1:1],1'b0} (bit 0 forced low); IF/ID <= bubble (NOP_INST, valid=0, ifid_pc=0); state <= RUN. Redirect wins over simultaneous stall. Redirect in HALTED cancels the speculative halt.
- stall=1, no redirect: pc, ifid_inst, ifid_pc, ifid_valid and state all hold.
- RUN normal: ifid_inst <= im_inst; ifid_pc <= pc; ifid_valid <= 1; pc <= pc + PC_INC modulo 2^ADDR_W (0xFFFE wraps to 0x0000).
- RUN normal with im_inst==HALT_INST: halt is latched to IF/ID as valid; pc holds; state <= HALTED.
- HALTED normal: pc holds; IF/ID <= bubble each unstalled cycle. Exits only via redirect or rst.
- First instruction after reset appears on ifid_* one edge after rst deasserts. Fetch-to-decode latency is one cycle.

Optional Feature:
FETCH_PERF_EN. When defined, adds outputs perf_fetch_cnt[31:0] and perf_stall_cnt[31:0]. perf_fetch_cnt counts edges that load a valid instruction. perf_stall_cnt counts edges with stall=1 and no redirect. Both reset to 0 and saturate at 32'hFFFFFFFF. When undefined, the ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package: ADDR_W/INST_W widths, NOP_INST, HALT_INST, RESET_PC, fetch state enum (RUN, HALTED).
- One sub-module is natural: ifid_reg. It holds inst/pc/valid with load, hold and flush controls.
- PC logic and FSM stay in if_fetch_stage.

Test Plan:
- Reset then run; im returns 0x1111 @0, 0x2222 @2, 0x3333 @4 -> ifid_inst sequence 0x1111/0x2222/0x3333; ifid_pc 0/2/4; ifid_valid 1 from the first edge after reset.
- stall=1 for 2 cycles at pc=4 -> im_address stays 4; ifid_inst stays 0x2222; resumes 0x3333 after release.
- redirect=1, target=0x0021, with stall=1 same cycle -> next pc=0x0020; ifid_valid=0 and ifid_inst=NOP for that edge; the following edge fetches @0x0020.
- im_inst=0xFFFF @0x000C -> ifid_inst=0xFFFF valid; then halted=1 and pc stays 0x000C with bubbles. redirect target 0x0010 -> halted=0, fetch @0x0010.
- pc=0xFFFE, normal fetch -> next im_address=0x0000. Assert rst mid-stream -> all outputs at reset values after that edge.
- With FETCH_PERF_EN: 5 fetches and 3 stalls -> perf_fetch_cnt=5, perf_stall_cnt=3. Without the macro, the bench compiles without the perf ports.
